// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// 32 x WIDTH architectural register file with one write-back port, two
// combinational read ports and a per-register pending ("scoreboard") bit.
// X31 is XZR: it always reads 0 and is always ready. Writes and issues to it
// are ignored.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   rst            : synchronous active-high reset (clears data, pending, count)
//   ReadRegister1  : read port 1 index
//   ReadRegister2  : read port 2 index
//   WriteRegister  : write-back destination index
//   WriteData      : write-back data
//   RegWrite       : write-back enable (also clears the destination pending bit)
//   IssueValid     : an instruction with a destination is issued this cycle
//   IssueRegister  : destination index of the issued instruction
//   ReadData1/2    : read data. Same-cycle write-back data is forwarded.
//   Ready1/2       : read data is final (XZR, forwarded, or not pending)
//   PendingCount   : number of registers currently marked pending
// -----------------------------------------------------------------------------
module register_file #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic             RegWrite,
    input  logic             IssueValid,
    input  logic [4:0]       IssueRegister,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2,
    output logic             Ready1,
    output logic             Ready2,
    output logic [5:0]       PendingCount
);

    localparam logic [4:0] XZR = 5'd31;

    // Entry 31 exists so every 5-bit index is in range, but it is never
    // written after reset and the read path masks it anyway.
    logic [WIDTH-1:0] regs_reg [0:31];
    logic [31:0]      pending_reg;
    logic [31:0]      pending_next;
    logic [5:0]       count_reg;
    logic [5:0]       count_next;

    logic wr_en;
    logic iss_en;
    logic set_new;
    logic clr_new;

    assign wr_en  = RegWrite && (WriteRegister != XZR);
    assign iss_en = IssueValid && (IssueRegister != XZR);

    // Per-register pending update. Issue wins over a same-cycle write-back
    // to the same register, so the bit ends set while the data is still
    // written.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_pending
            if (gi == 31) begin : g_xzr
                assign pending_next[gi] = 1'b0;
            end else begin : g_gpr
                assign pending_next[gi] =
                    (iss_en && (IssueRegister == 5'(gi))) ||
                    (pending_reg[gi] && !(RegWrite && (WriteRegister == 5'(gi))));
            end
        end
    endgenerate

    // The counter tracks population incrementally. A re-issue of an already
    // pending bit is not "new", and a write-back whose clear is overridden
    // by a same-register issue does not count as a clear. Both are needed to
    // keep the count exact and therefore bounded to 0..31.
    assign set_new = iss_en && !pending_reg[IssueRegister];
    assign clr_new = wr_en && pending_reg[WriteRegister] &&
                     !(iss_en && (IssueRegister == WriteRegister));

    assign count_next = count_reg + {5'd0, set_new} - {5'd0, clr_new};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_reg[i] <= '0;
            end
            pending_reg <= '0;
            count_reg   <= '0;
        end else begin
            if (wr_en) begin
                regs_reg[WriteRegister] <= WriteData;
            end
            pending_reg <= pending_next;
            count_reg   <= count_next;
        end
    end

    assign PendingCount = count_reg;

    // Two identical combinational read ports.
    logic [4:0]       rd_idx  [2];
    logic [WIDTH-1:0] rd_data [2];
    logic             rd_rdy  [2];

    assign rd_idx[0] = ReadRegister1;
    assign rd_idx[1] = ReadRegister2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            logic is_zr;
            logic hit;

            assign is_zr = (rd_idx[gi] == XZR);
            assign hit   = wr_en && (WriteRegister == rd_idx[gi]);

            always_comb begin
                rd_data[gi] = regs_reg[rd_idx[gi]];
                if (is_zr) begin
                    rd_data[gi] = '0;
                end else if (hit) begin
                    rd_data[gi] = WriteData;
                end
            end

            assign rd_rdy[gi] = is_zr || hit || !pending_reg[rd_idx[gi]];
        end
    endgenerate

    assign ReadData1 = rd_data[0];
    assign ReadData2 = rd_data[1];
    assign Ready1    = rd_rdy[0];
    assign Ready2    = rd_rdy[1];

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//
// Directed bench for register_file. Every observation point pushes the
// expected read-port/ready/count values onto a queue, and the values are
// popped and compared once the combinational outputs have settled.
// -----------------------------------------------------------------------------
module tb_register_file;

    localparam int WIDTH = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       ReadRegister1;
    logic [4:0]       ReadRegister2;
    logic [4:0]       WriteRegister;
    logic [WIDTH-1:0] WriteData;
    logic             RegWrite;
    logic             IssueValid;
    logic [4:0]       IssueRegister;
    logic [WIDTH-1:0] ReadData1;
    logic [WIDTH-1:0] ReadData2;
    logic             Ready1;
    logic             Ready2;
    logic [5:0]       PendingCount;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] d1;
        logic             r1;
        logic [WIDTH-1:0] d2;
        logic             r2;
        logic [5:0]       cnt;
    } exp_t;

    exp_t sb_q[$];

    register_file #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite),
        .IssueValid    (IssueValid),
        .IssueRegister (IssueRegister),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .Ready1        (Ready1),
        .Ready2        (Ready2),
        .PendingCount  (PendingCount)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cmp(input string tag, input string field,
                       input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
        end
    endtask

    // Step past the next rising edge and away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RegWrite   = 1'b0;
        IssueValid = 1'b0;
    endtask

    // Set read indices, queue the expectation, let outputs settle, then
    // pop and compare against the DUT.
    task automatic expect_out(input string tag,
                              input logic [4:0] a1, input logic [4:0] a2,
                              input logic [WIDTH-1:0] d1, input logic r1,
                              input logic [WIDTH-1:0] d2, input logic r2,
                              input logic [5:0] cnt);
        exp_t e;
        ReadRegister1 = a1;
        ReadRegister2 = a2;
        e.tag = tag; e.d1 = d1; e.r1 = r1; e.d2 = d2; e.r2 = r2; e.cnt = cnt;
        sb_q.push_back(e);
        #1;
        e = sb_q.pop_front();
        cmp(e.tag, "ReadData1", ReadData1, e.d1);
        cmp(e.tag, "Ready1", WIDTH'(Ready1), WIDTH'(e.r1));
        cmp(e.tag, "ReadData2", ReadData2, e.d2);
        cmp(e.tag, "Ready2", WIDTH'(Ready2), WIDTH'(e.r2));
        cmp(e.tag, "PendingCount", WIDTH'(PendingCount), WIDTH'(e.cnt));
        $display("txn %-14s rr1=%0d rr2=%0d d1=%h r1=%0b d2=%h r2=%0b cnt=%0d",
                 tag, a1, a2, ReadData1, Ready1, ReadData2, Ready2, PendingCount);
    endtask

    localparam logic [WIDTH-1:0] V5 = 64'h0123_4567_89AB_CDEF;
    localparam logic [WIDTH-1:0] VF = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        rst = 1'b1;
        ReadRegister1 = '0; ReadRegister2 = '0;
        WriteRegister = '0; WriteData = '0; RegWrite = 1'b0;
        IssueValid = 1'b0; IssueRegister = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        expect_out("reset_a", 5'd0, 5'd30, 0, 1, 0, 1, 0);
        expect_out("reset_b", 5'd17, 5'd31, 0, 1, 0, 1, 0);

        // Basic write/read of X5 (bypass visible in the writing cycle)
        RegWrite = 1; WriteRegister = 5'd5; WriteData = V5;
        expect_out("wr5_bypass", 5'd5, 5'd6, V5, 1, 0, 1, 0);
        tick(); idle();
        expect_out("rd5", 5'd5, 5'd0, V5, 1, 0, 1, 0);

        // Bypass on port 2
        RegWrite = 1; WriteRegister = 5'd7; WriteData = VF;
        expect_out("byp7", 5'd5, 5'd7, V5, 1, VF, 1, 0);
        tick(); idle();
        expect_out("rd7", 5'd7, 5'd7, VF, 1, VF, 1, 0);

        // XZR: write and issue to 31 are ignored
        RegWrite = 1; WriteRegister = 5'd31; WriteData = 64'h1;
        IssueValid = 1; IssueRegister = 5'd31;
        expect_out("xzr_same", 5'd31, 5'd31, 0, 1, 0, 1, 0);
        tick(); idle();
        expect_out("xzr_after", 5'd31, 5'd31, 0, 1, 0, 1, 0);

        // Scoreboard: issue X3 then X4
        IssueValid = 1; IssueRegister = 5'd3;
        tick();
        IssueRegister = 5'd4;
        tick(); idle();
        expect_out("pend34", 5'd3, 5'd4, 0, 0, 0, 0, 2);
        RegWrite = 1; WriteRegister = 5'd3; WriteData = 64'd10;
        expect_out("wr3_bypass", 5'd3, 5'd4, 64'd10, 1, 0, 0, 2);
        tick(); idle();
        expect_out("wr3_done", 5'd3, 5'd4, 64'd10, 1, 0, 0, 1);

        // Write to a non-pending register leaves pending state alone
        RegWrite = 1; WriteRegister = 5'd5; WriteData = 64'hABCD;
        tick(); idle();
        expect_out("wr_nonpend", 5'd5, 5'd4, 64'hABCD, 1, 0, 0, 1);

        // Re-issue of pending X4: count unchanged
        IssueValid = 1; IssueRegister = 5'd4;
        tick(); idle();
        expect_out("reissue4", 5'd4, 5'd3, 0, 0, 64'd10, 1, 1);

        // X9 pending, then issue + write X9 together
        IssueValid = 1; IssueRegister = 5'd9;
        tick(); idle();
        expect_out("pend9", 5'd9, 5'd4, 0, 0, 0, 0, 2);
        IssueValid = 1; IssueRegister = 5'd9;
        RegWrite = 1; WriteRegister = 5'd9; WriteData = 64'h22;
        tick(); idle();
        expect_out("iss_wr9", 5'd9, 5'd9, 64'h22, 0, 64'h22, 0, 2);

        // Set X2 while clearing a different pending register X6
        IssueValid = 1; IssueRegister = 5'd6;
        tick(); idle();
        expect_out("pend6", 5'd6, 5'd2, 0, 0, 0, 1, 3);
        IssueValid = 1; IssueRegister = 5'd2;
        RegWrite = 1; WriteRegister = 5'd6; WriteData = 64'h66;
        tick(); idle();
        expect_out("set2_clr6", 5'd6, 5'd2, 64'h66, 1, 0, 0, 3);

        // Arrange exactly three pending (2, 9, 12) with X12 = 0x55
        RegWrite = 1; WriteRegister = 5'd4; WriteData = 64'h44;
        tick(); idle();
        IssueValid = 1; IssueRegister = 5'd12;
        RegWrite = 1; WriteRegister = 5'd12; WriteData = 64'h55;
        tick(); idle();
        expect_out("pre_rst", 5'd12, 5'd4, 64'h55, 0, 64'h44, 1, 3);

        // Reset mid-operation; rst overrides a concurrent write and issue
        rst = 1;
        RegWrite = 1; WriteRegister = 5'd1; WriteData = 64'hAA;
        IssueValid = 1; IssueRegister = 5'd8;
        tick(); idle();
        rst = 0;
        expect_out("post_rst_a", 5'd12, 5'd1, 0, 1, 0, 1, 0);
        expect_out("post_rst_b", 5'd8, 5'd9, 0, 1, 0, 1, 0);

        // Write-back of a formerly pending register after reset: data only
        RegWrite = 1; WriteRegister = 5'd9; WriteData = 64'h99;
        tick(); idle();
        expect_out("wr9_postrst", 5'd9, 5'd12, 64'h99, 1, 0, 1, 0);

        // Fill every pending bit: count reaches 31 and then holds
        for (int i = 0; i < 32; i++) begin
            IssueValid = 1; IssueRegister = 5'(i);
            tick();
        end
        idle();
        expect_out("all_pend", 5'd0, 5'd30, 0, 0, 0, 0, 31);
        IssueValid = 1; IssueRegister = 5'd17;
        tick(); idle();
        expect_out("all_reissue", 5'd17, 5'd31, 0, 0, 0, 1, 31);

        // Drain all of them through write-back
        for (int i = 0; i < 31; i++) begin
            RegWrite = 1; WriteRegister = 5'(i); WriteData = WIDTH'(i + 100);
            tick();
        end
        idle();
        expect_out("drained", 5'd0, 5'd30, 64'd100, 1, 64'd130, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter WIDTH, default 64: data width of every register, read port and write port.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port ReadRegister1, input, 5: index for read port 1 (feeds ALU value1).
REQ-005 SHALL have port ReadRegister2, input, 5: index for read port 2 (feeds ALU value2).
REQ-006 SHALL have port WriteRegister, input, 5: write-back destination index.
REQ-007 SHALL have port WriteData, input, WIDTH: write-back data (ALUResult or load data).
REQ-008 SHALL have port RegWrite, input, 1: write-back enable.
REQ-009 SHALL have port IssueValid, input, 1: an instruction with a pending destination is being issued this cycle.
REQ-010 SHALL have port IssueRegister, input, 5: destination index of the issued instruction.
REQ-011 SHALL have port ReadData1, output, WIDTH: read port 1 data.
REQ-012 SHALL have port ReadData2, output, WIDTH: read port 2 data.
REQ-013 SHALL have port Ready1, output, 1: ReadData1 is final, with no write outstanding.
REQ-014 SHALL have port Ready2, output, 1: ReadData2 is final, with no write outstanding.
REQ-015 SHALL have port PendingCount, output, 6: number of registers currently marked pending (0..31).

Function
REQ-016 SHALL hold 32 registers X0..X31 of WIDTH bits; X31 is XZR.
REQ-017 SHALL make both reads combinational, with zero-cycle latency from index to data.
REQ-018 SHALL return 0 with Ready=1 on any read of index 31, regardless of writes or issues.
REQ-019 SHALL update register WriteRegister with WriteData at the clock edge when RegWrite=1 and WriteRegister!=31; a write to index 31 has no effect.
REQ-020 SHALL bypass same-cycle writes: when RegWrite=1, WriteRegister!=31 and WriteRegister equals a read index, that port outputs WriteData and Ready=1 in the same cycle.
REQ-021 SHALL keep one pending bit per register; IssueValid=1 with IssueRegister!=31 sets the bit at the clock edge; issue to index 31 is ignored.
REQ-022 SHALL clear the pending bit of WriteRegister at the clock edge when RegWrite=1.
REQ-023 SHALL give issue priority over write-back when both target the same register in the same cycle: the data is written and the pending bit ends set.
REQ-024 SHALL accept a re-issue to an already-pending register without error; the bit stays set and PendingCount does not change.
REQ-025 SHALL accept a write to a non-pending register normally, without changing any pending state.
REQ-026 SHALL drive ReadyN = (index==31) | bypass hit | ~pending[index].
REQ-027 SHALL maintain PendingCount as a registered counter equal to the population of the pending bits after every edge:
- +1 on a newly set bit
- -1 on a newly cleared bit
- net 0 when one bit is set and a different bit is cleared in the same cycle
REQ-028 SHALL never let PendingCount wrap; it stays within 0..31 by construction.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, clear all registers to 0, clear all pending bits and set PendingCount=0; rst overrides RegWrite and IssueValid in that cycle.
REQ-030 SHALL, after reset, read 0 with Ready1=Ready2=1 on every index.
REQ-031 SHALL discard all outstanding pending state when reset is asserted mid-operation; a write-back arriving after reset updates data only.

Verification
REQ-032 SHALL cover basic write/read: reset, then write X5=64'h0123_4567_89AB_CDEF -> next cycle ReadRegister1=5 gives that value with Ready1=1.
REQ-033 SHALL cover bypass: RegWrite with WriteRegister=7, WriteData=64'hFFFF_FFFF_FFFF_FFFF, and ReadRegister2=7 in the same cycle -> ReadData2=64'hFFFF_FFFF_FFFF_FFFF, Ready2=1 combinationally.
REQ-034 SHALL cover XZR: write X31=64'h1, issue X31, read index 31 on both ports -> both read 0, Ready=1, PendingCount=0.
REQ-035 SHALL cover the scoreboard: issue X3 then X4 -> PendingCount=2 and Ready1=0 for index 3; write X3=10 -> PendingCount=1, Ready1=1, ReadData1=10.
REQ-036 SHALL cover simultaneous events: with X9 pending, issue X9 and write X9=64'h22 in the same cycle -> X9 reads 64'h22, Ready=0, PendingCount unchanged; in another cycle, issue X2 while writing pending X6 -> PendingCount unchanged.
REQ-037 SHALL cover reset mid-operation: with 3 registers pending, including X12=64'h55, assert rst for one cycle -> PendingCount=0, X12 reads 0 with Ready=1.
